// File: rtl/serial_word_tx.sv
// Framed parallel-to-serial transmitter: start, data LSB-first, optional even
// parity, stop. All state advances on the falling edge of clk.
module serial_word_tx #(
    parameter int WIDTH      = 4,
    parameter bit PARITY_EN  = 1'b1,
    parameter int BIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam int IW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] LAST_CNT = CW'(BIT_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_shift;
    logic             r_par;
    logic             r_done;

    logic w_bit_end;

    assign w_bit_end = (r_cnt == LAST_CNT);

    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (din_valid) begin
                    r_shift <= din;
                    r_par   <= ^din;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_state <= S_START;
                end
            end else if (!w_bit_end) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                // every bit boundary restarts the per-bit cycle count
                r_cnt <= '0;
                case (r_state)
                    S_START: begin
                        r_idx   <= '0;
                        r_state <= S_DATA;
                    end
                    S_DATA: begin
                        r_shift <= r_shift >> 1;
                        if (r_idx == LAST_IDX) begin
                            r_state <= PARITY_EN ? S_PARITY : S_STOP;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                    S_PARITY: r_state <= S_STOP;
                    S_STOP: begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        tx = 1'b1;
        case (r_state)
            S_START:  tx = 1'b0;
            S_DATA:   tx = r_shift[0];
            S_PARITY: tx = r_par;
            default:  tx = 1'b1;
        endcase
    end

    assign busy      = (r_state != S_IDLE);
    assign din_ready = (r_state == S_IDLE);
    assign done      = r_done;

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: default build plus a
// BIT_CYCLES=3, no-parity build sharing clock and reset.
module tb_serial_word_tx;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic [3:0] din = 4'h0;
    logic       v = 1'b0;
    logic       ready, tx, busy, done;
    logic [3:0] din3 = 4'h0;
    logic       v3 = 1'b0;
    logic       ready3, tx3, busy3, done3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_word_tx dut (
        .clk(clk), .clr_n(clr_n), .din(din), .din_valid(v),
        .din_ready(ready), .tx(tx), .busy(busy), .done(done)
    );

    serial_word_tx #(.WIDTH(4), .PARITY_EN(1'b0), .BIT_CYCLES(3)) dut3 (
        .clk(clk), .clr_n(clr_n), .din(din3), .din_valid(v3),
        .din_ready(ready3), .tx(tx3), .busy(busy3), .done(done3)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one falling (active) edge, then sample just after the rising edge
    task automatic step();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // called while sampling the start-bit cycle; ends sampling the done cycle
    task automatic expect_frame(input string tag, input logic [6:0] bits,
                                input bit disturb);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("%s tx%0d", tag, i), tx, bits[6-i]);
            check($sformatf("%s busy%0d", tag, i), busy, 1);
            check($sformatf("%s ready%0d", tag, i), ready, 0);
            check($sformatf("%s nodone%0d", tag, i), done, 0);
            if (disturb && i == 2) begin
                din = 4'hF;
                v = 1'b1;
            end
            if (disturb && i == 4) v = 1'b0;
            step();
        end
        check({tag, " done"}, done, 1);
        check({tag, " idle busy"}, busy, 0);
        check({tag, " idle ready"}, ready, 1);
        check({tag, " idle tx"}, tx, 1);
    endtask

    initial begin
        logic [5:0] e3;

        // reset held with valid asserted: nothing may start
        clr_n = 1'b0;
        din = 4'hB;
        v = 1'b1;
        v3 = 1'b1;
        repeat (3) step();
        check("rst tx", tx, 1);
        check("rst ready", ready, 1);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst tx3", tx3, 1);
        check("rst busy3", busy3, 0);
        v = 1'b0;
        v3 = 1'b0;
        clr_n = 1'b1;
        step();
        check("post rst tx", tx, 1);
        check("post rst busy", busy, 0);

        // single frame 1011
        din = 4'b1011;
        v = 1'b1;
        step();
        v = 1'b0;
        expect_frame("single", 7'b0110111, 1'b0);
        step();
        check("single done low", done, 0);

        // back-to-back 0 then F with valid held
        din = 4'h0;
        v = 1'b1;
        step();
        din = 4'hF;
        expect_frame("b2b0", 7'b0000001, 1'b0);
        step();
        v = 1'b0;
        expect_frame("b2bF", 7'b0111101, 1'b0);
        step();
        check("b2b end done", done, 0);
        check("b2b end busy", busy, 0);

        // BIT_CYCLES=3, no parity, 0110
        din3 = 4'b0110;
        v3 = 1'b1;
        step();
        v3 = 1'b0;
        e3 = 6'b001101;
        for (int i = 0; i < 18; i++) begin
            check($sformatf("bc3 tx%0d", i), tx3, e3[5 - i/3]);
            check($sformatf("bc3 busy%0d", i), busy3, 1);
            check($sformatf("bc3 nodone%0d", i), done3, 0);
            step();
        end
        check("bc3 done", done3, 1);
        check("bc3 idle busy", busy3, 0);
        check("bc3 idle ready", ready3, 1);
        step();
        check("bc3 done low", done3, 0);

        // mid-frame din change and valid pulse must be ignored
        din = 4'b1001;
        v = 1'b1;
        step();
        v = 1'b0;
        expect_frame("mid", 7'b0100101, 1'b1);
        step();
        check("mid no refire busy", busy, 0);
        check("mid no refire tx", tx, 1);
        check("mid done low", done, 0);

        // asynchronous reset during data bit 2
        din = 4'b0101;
        v = 1'b1;
        step();
        v = 1'b0;
        repeat (3) step();
        check("pre abort tx d2", tx, 1);
        check("pre abort busy", busy, 1);
        #2;
        clr_n = 1'b0;
        #1;
        check("abort tx", tx, 1);
        check("abort busy", busy, 0);
        check("abort ready", ready, 1);
        check("abort done", done, 0);
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        step();
        check("after abort done", done, 0);
        check("after abort busy", busy, 0);
        din = 4'b1011;
        v = 1'b1;
        step();
        v = 1'b0;
        expect_frame("post", 7'b0110111, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
